// File: rtl/data_mem_busywait.sv
// rtl/data_mem_busywait.sv - data memory model with BUSYWAIT stall handshake and RV32 access modes
//
// Purpose: behavioural-but-synthesizable data memory for the CPU memory stage.
//   Every request stalls the pipeline for LATENCY cycles in ACCESS, then
//   completes in a single DONE cycle where READ_DATA / MEM_ERROR are valid.
// Ports:
//   CLK            rising-edge clock
//   RESET          asynchronous active-high reset
//   MEM_READ       load request, held by the CPU until completion
//   MEM_WRITE      store request, held by the CPU until completion
//   MEM_ADDRESS    byte address (wraps modulo 4*DEPTH_WORDS)
//   MEM_WRITE_DATA store data, byte/half taken from the LSBs
//   FUNCT3         RV32 load/store access mode
//   READ_DATA      load result (0 after an errored access, else held)
//   BUSYWAIT       combinational stall request
//   MEM_ERROR      registered error flag, high only in DONE
module data_mem_busywait #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 4,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  MEM_READ,
  input  logic                  MEM_WRITE,
  input  logic [ADDR_WIDTH-1:0] MEM_ADDRESS,
  input  logic [31:0]           MEM_WRITE_DATA,
  input  logic [2:0]            FUNCT3,
  output logic [31:0]           READ_DATA,
  output logic                  BUSYWAIT,
  output logic                  MEM_ERROR
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  // Only the word index plus byte-lane bits are kept; the rest wraps away.
  localparam int LA_W  = IDX_W + 2;
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic [LA_W-1:0]   addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [2:0]        f3_q, f3_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [31:0]       mem [DEPTH_WORDS];

  logic              execute;
  logic [IDX_W-1:0]  idx;
  logic [1:0]        lane;
  logic [4:0]        sh_amt;
  logic [31:0]       word;
  logic [7:0]        byte_v;
  logic [15:0]       half_v;
  logic [31:0]       load_v;
  logic [31:0]       st_mask;
  logic [31:0]       merged;
  logic              load_f3_ok;
  logic              store_f3_ok;
  logic              acc_err;
  logic              mem_we;

  generate
    if (ADDR_WIDTH > LA_W) begin : g_addr_hi
      logic unused_addr_hi;
      assign unused_addr_hi = ^MEM_ADDRESS[ADDR_WIDTH-1:LA_W];
    end
  endgenerate

  // Access datapath, evaluated from latched request fields only.
  always_comb begin
    execute = (state_q == S_ACCESS) && (cnt_q == CNT_W'(LATENCY - 1));
    idx     = addr_q[LA_W-1:2];
    lane    = addr_q[1:0];
    sh_amt  = {lane, 3'b000};
    word    = mem[idx];
    byte_v  = 8'(word >> sh_amt);
    // A valid half access is always 2-byte aligned, so lane[1] picks the half.
    half_v  = lane[1] ? word[31:16] : word[15:0];

    load_f3_ok  = f3_q inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    store_f3_ok = f3_q inside {3'b000, 3'b001, 3'b010};
    acc_err = (rd_q && wr_q)
            || (rd_q && !load_f3_ok)
            || (wr_q && !store_f3_ok)
            || ((f3_q[1:0] == 2'b01) && lane[0])
            || ((f3_q[1:0] == 2'b10) && (lane != 2'b00));

    case (f3_q)
      3'b000:  load_v = {{24{byte_v[7]}}, byte_v};
      3'b001:  load_v = {{16{half_v[15]}}, half_v};
      3'b010:  load_v = word;
      3'b100:  load_v = {24'h0, byte_v};
      3'b101:  load_v = {16'h0, half_v};
      default: load_v = 32'h0;
    endcase

    case (f3_q[1:0])
      2'b00:   st_mask = 32'h0000_00FF << sh_amt;
      2'b01:   st_mask = 32'h0000_FFFF << sh_amt;
      default: st_mask = 32'hFFFF_FFFF;
    endcase
    merged = (word & ~st_mask) | ((wdata_q << sh_amt) & st_mask);
    mem_we = execute && wr_q && !acc_err;
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    f3_d    = f3_q;
    rdata_d = rdata_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (MEM_READ || MEM_WRITE) begin
          state_d = S_ACCESS;
          cnt_d   = '0;
          rd_d    = MEM_READ;
          wr_d    = MEM_WRITE;
          addr_d  = MEM_ADDRESS[LA_W-1:0];
          wdata_d = MEM_WRITE_DATA;
          f3_d    = FUNCT3;
        end
      end
      S_ACCESS: begin
        cnt_d = cnt_q + 1'b1;
        if (execute) begin
          state_d = S_DONE;
          err_d   = acc_err;
          if (acc_err) begin
            rdata_d = 32'h0;
          end else if (rd_q) begin
            rdata_d = load_v;
          end
        end
      end
      // Request inputs are still those of the completing instruction here.
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      f3_q    <= 3'b000;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      f3_q    <= f3_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Array has no reset; contents survive RESET and start undefined.
  always_ff @(posedge CLK) begin
    if (mem_we && !RESET) begin
      mem[idx] <= merged;
    end
  end

  assign BUSYWAIT  = !RESET && (((state_q == S_IDLE) && (MEM_READ || MEM_WRITE))
                                || (state_q == S_ACCESS));
  assign READ_DATA = rdata_q;
  assign MEM_ERROR = err_q;

endmodule

// File: doc/data_mem_busywait.md
# data_mem_busywait

Parametrised data-memory model with a BUSYWAIT handshake and RV32 byte/half/word access modes. It sits on the CPU's memory-stage port (MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITE_DATA, READ_DATA, BUSYWAIT) and replaces statically driven READ_DATA/BUSYWAIT stimulus. Each access stalls the pipeline for a configurable number of cycles, then completes in one handshake cycle. Alignment and opcode errors are flagged.

## Interface
- DEPTH_WORDS, 256: number of 32-bit words; must be a power of two.
- LATENCY, 4: cycles spent in ACCESS per request; must be ≥1.
- ADDR_WIDTH, 32: width of MEM_ADDRESS.

Ports (one clock; reset is asynchronous and active-high):
- CLK  in  1  rising-edge clock.
- RESET  in  1  asynchronous, active-high reset.
- MEM_READ  in  1  load request, level-held by the CPU until completion.
- MEM_WRITE  in  1  store request, level-held by the CPU until completion.
- MEM_ADDRESS  in  ADDR_WIDTH  byte address.
- MEM_WRITE_DATA  in  32  store data; byte/half taken from the LSBs.
- FUNCT3  in  3  access mode (RV32 load/store funct3).
- READ_DATA  out  32  load result, extended per FUNCT3.
- BUSYWAIT  out  1  stall request to the CPU.
- MEM_ERROR  out  1  one-cycle error flag in DONE.

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE → ACCESS when MEM_READ or MEM_WRITE is high at the rising edge.
  - The edge latches op, address, write data and FUNCT3.
  - The cycle counter is cleared.
- ACCESS: counter increments every edge.
  - At the edge where counter == LATENCY-1, the access executes and the FSM enters DONE.
- DONE → IDLE unconditionally. Request inputs are ignored in DONE, because the completing instruction is still presenting them.
- Input changes during ACCESS are ignored; only latched values are used.
- Word index = latched address[log2(DEPTH_WORDS)+1:2]. Upper bits are discarded, so addresses wrap modulo 4·DEPTH_WORDS. Out-of-range is not an error.
- Loads:
  - 000 lb: sign-extended byte.
  - 001 lh: sign-extended half.
  - 010 lw: full word.
  - 100 lbu: zero-extended byte.
  - 101 lhu: zero-extended half.
  - Byte/half lane is selected by address[1:0].
- Stores:
  - 000 sb, 001 sh, 010 sw.
  - Only the addressed lanes are written; other bytes are preserved.
- Errors (MEM_ERROR=1 in DONE): any of the following.
  - Half access with address[0]=1.
  - Word access with address[1:0]≠0.
  - Unlisted FUNCT3 for the op.
  - MEM_READ and MEM_WRITE both high at acceptance.
- On error, no array write occurs and READ_DATA is set to 0.
- READ_DATA updates only on completion of a load (or any errored access). Otherwise it holds its value.
- Memory array is not cleared by reset; initial contents are undefined (X) in simulation.

## Timing
- BUSYWAIT = !RESET && ((IDLE && (MEM_READ||MEM_WRITE)) || ACCESS). It is combinational, so the stall is visible in the request cycle itself.
- Request first seen in cycle 0:
  - BUSYWAIT is high in cycles 0…LATENCY.
  - DONE occurs in cycle LATENCY+1, with BUSYWAIT=0 and READ_DATA/MEM_ERROR valid.
  - The CPU advances on the edge ending DONE.
- Back-to-back accesses: the next request appears in the cycle after DONE (IDLE) and is accepted normally. There is no dead cycle beyond DONE.
- Reset values: FSM=IDLE, counter=0, READ_DATA=0, MEM_ERROR=0, BUSYWAIT=0 (forced while RESET is high).
- Reset mid-ACCESS: the access is abandoned with no write. The FSM is in IDLE after reset deasserts. A still-held request is then re-accepted as new.
- MEM_ERROR is registered, high only during the DONE cycle.

## Test plan
- LATENCY=4: sw of 0xDEADBEEF to 0x10, then lw from 0x10 → BUSYWAIT high for exactly 5 cycles on each access; READ_DATA=0xDEADBEEF in DONE; MEM_ERROR=0.
- Memory word at 0x20 = 0x80FF7F01:
  - lb 0x23 → 0xFFFFFF80.
  - lbu 0x23 → 0x00000080.
  - lh 0x22 → 0xFFFF80FF.
  - lhu 0x20 → 0x00007F01.
- Word at 0x30 = 0x11223344; sb 0xAA to 0x31 → word reads back 0x1122AA44. Then sh 0xBBCC to 0x32 → word reads back 0xBBCCAA44.
- Misaligned lw 0x42, lh 0x41, and MEM_READ+MEM_WRITE together → MEM_ERROR=1 for one cycle in DONE; READ_DATA=0; target word unchanged.
- Address wrap: with DEPTH_WORDS=256, sw 0x5 to 0x400, then lw 0x000 → 0x00000005.
- RESET asserted in the 2nd ACCESS cycle of sw 0x77 to 0x50 → BUSYWAIT=0 immediately; word at 0x50 is unchanged (read value equals the pre-test value); after deassert, the held request completes normally.
